// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES tables, key-shift schedule, permutation helpers and FSM encodings
// Bit numbering follows the DES standard: table entry 1 is the MSB of the vector.
package des_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    // Indexed by {row[1:0], col[3:0]}, row = outer bits of the 6-bit group.
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    localparam int SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic int cum_shift(input int n);
        int s;
        s = 0;
        for (int i = 1; i <= 16; i++) begin
            if (i <= n) s += SHIFTS[i];
        end
        return s;
    endfunction

    // True when round j (1..16) rotates by two positions.
    function automatic logic shift_two(input logic [4:0] j);
        logic t;
        t = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (5'(i) == j) t = (SHIFTS[i] == 2);
        end
        return t;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Rotate by a constant amount; only ever called with elaboration-time n.
    function automatic logic [27:0] rol28_n(input logic [27:0] x, input int n);
        logic [27:0] y;
        y = x;
        for (int i = 0; i < 28; i++) begin
            if (i < n) y = {y[26:0], y[27]};
        end
        return y;
    endfunction

    function automatic logic [63:0] des_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TAB[i])];
        return y;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TAB[i])];
        return y;
    endfunction

    function automatic logic [55:0] des_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TAB[i])];
        return y;
    endfunction

    function automatic logic [47:0] des_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TAB[i])];
        return y;
    endfunction

    function automatic logic [47:0] des_e(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TAB[i])];
        return y;
    endfunction

    function automatic logic [31:0] des_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TAB[i])];
        return y;
    endfunction

    function automatic logic [31:0] des_sbox(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  b;
        for (int i = 0; i < 8; i++) begin
            b = x[6'(47 - 6 * i) -: 6];
            y[5'(31 - 4 * i) -: 4] = 4'(SBOX[i][{b[5], b[0], b[4:1]}]);
        end
        return y;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        return des_p(des_sbox(des_e(r) ^ k));
    endfunction

endpackage

// File: rtl/des_iter_core_if.sv
// rtl/des_iter_core_if.sv - block handshake bundle between source/sink (master) and the DES core (slave)
// Signals: in_valid/in_ready/in_mode/in_data/in_key (block in), out_valid/out_ready/out_data/out_weak (result out).
interface des_iter_core_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [63:0] in_data;
    logic [63:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_weak;

    modport master (
        output in_valid, in_mode, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, out_weak
    );

    modport slave (
        input  in_valid, in_mode, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, out_weak
    );
endinterface

// File: rtl/des_feistel_round.sv
// rtl/des_feistel_round.sv - one combinational DES Feistel round
// Ports: l_in, r_in (32b halves), subkey (48b) -> l_out = r_in, r_out = l_in ^ f(r_in, subkey).
module des_feistel_round
    import des_pkg::*;
(
    input  logic [31:0] l_in,
    input  logic [31:0] r_in,
    input  logic [47:0] subkey,
    output logic [31:0] l_out,
    output logic [31:0] r_out
);
    assign l_out = r_in;
    assign r_out = l_in ^ des_f(r_in, subkey);
endmodule

// File: rtl/des_iter_core.sv
// rtl/des_iter_core.sv - iterative handshaked DES encrypt/decrypt engine
// Ports: clk, rst_n (async, active low), bus (des_iter_core_if.slave).
// Params: NUM_ROUNDS (1..16, multiple of ROUNDS_PER_CYCLE), ROUNDS_PER_CYCLE (1, 2, 4).
// Optional: define DES_WEAK_KEY_EN to flag weak keys on out_weak; otherwise out_weak is 0.
module des_iter_core
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS       = 16,
    parameter int ROUNDS_PER_CYCLE = 1
)(
    input  logic           clk,
    input  logic           rst_n,
    des_iter_core_if.slave bus
);
    // Decrypt walks the schedule backwards, so C/D start at the position
    // reached after the last encrypt round.
    localparam int DEC_ROT = cum_shift(NUM_ROUNDS) % 28;

    logic [1:0]  state_q;
    logic [4:0]  cnt_q;
    logic        mode_q;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [63:0] out_data_q;

    logic [55:0] key_cd;
    logic [63:0] ip_data;
    assign key_cd  = des_pc1(bus.in_key);
    assign ip_data = des_ip(bus.in_data);

    // Key schedule for the rounds done this cycle.
    logic [ROUNDS_PER_CYCLE-1:0][47:0] subkey;
    logic [27:0] c_t, d_t, c_nxt, d_nxt;
    logic [4:0]  j;

    always_comb begin
        subkey = '0;
        c_t    = c_q;
        d_t    = d_q;
        j      = '0;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            j = cnt_q + 5'(k + 1);
            if (!mode_q) begin
                c_t = rol28(c_t, shift_two(j));
                d_t = rol28(d_t, shift_two(j));
                subkey[k] = des_pc2({c_t, d_t});
            end else begin
                subkey[k] = des_pc2({c_t, d_t});
                c_t = ror28(c_t, shift_two(5'(NUM_ROUNDS + 1) - j));
                d_t = ror28(d_t, shift_two(5'(NUM_ROUNDS + 1) - j));
            end
        end
        c_nxt = c_t;
        d_nxt = d_t;
    end

    logic [ROUNDS_PER_CYCLE:0][31:0] l_chain, r_chain;
    assign l_chain[0] = l_q;
    assign r_chain[0] = r_q;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        des_feistel_round u_round (
            .l_in   (l_chain[g]),
            .r_in   (r_chain[g]),
            .subkey (subkey[g]),
            .l_out  (l_chain[g+1]),
            .r_out  (r_chain[g+1])
        );
    end

    logic last_step;
    assign last_step = (cnt_q + 5'(ROUNDS_PER_CYCLE)) == 5'(NUM_ROUNDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            l_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            out_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        l_q     <= ip_data[63:32];
                        r_q     <= ip_data[31:0];
                        c_q     <= bus.in_mode ? rol28_n(key_cd[55:28], DEC_ROT) : key_cd[55:28];
                        d_q     <= bus.in_mode ? rol28_n(key_cd[27:0], DEC_ROT) : key_cd[27:0];
                        mode_q  <= bus.in_mode;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    l_q   <= l_chain[ROUNDS_PER_CYCLE];
                    r_q   <= r_chain[ROUNDS_PER_CYCLE];
                    c_q   <= c_nxt;
                    d_q   <= d_nxt;
                    cnt_q <= cnt_q + 5'(ROUNDS_PER_CYCLE);
                    if (last_step) begin
                        // Final round output is taken with halves swapped.
                        out_data_q <= des_fp({r_chain[ROUNDS_PER_CYCLE], l_chain[ROUNDS_PER_CYCLE]});
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = out_data_q;

`ifdef DES_WEAK_KEY_EN
    logic weak_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weak_q <= 1'b0;
        end else if (state_q == ST_IDLE && bus.in_valid) begin
            weak_q <= ((key_cd[55:28] == '0) || (&key_cd[55:28])) &&
                      ((key_cd[27:0]  == '0) || (&key_cd[27:0]));
        end else if (state_q == ST_DONE && bus.out_ready) begin
            weak_q <= 1'b0;
        end
    end
    assign bus.out_weak = weak_q & (state_q == ST_DONE);
`else
    assign bus.out_weak = 1'b0;
`endif

endmodule
